rpsc_interlock_seq: RTL and testbench

Parametrised interlock/sequencer card for the RF power-supply control chain: the next generation of the fixed-function card logic. It aggregates N maskable alarm inputs through per-input synchronisers and debounce filters, and runs a permit state machine (IDLE/READY/RAMP/ON/TRIP) with a programmable power-supply settle timer. It captures the first fault and counts trips, with latched or auto-recovering trip behaviour.

---
 rtl/rpsc_interlock_seq.sv | 170 +++++++++++++++++
 tb/tb_rpsc_interlock_seq.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpsc_interlock_seq.sv
// Interlock/sequencer for the RF power-supply chain: synchronised, debounced inputs
// feeding an IDLE/READY/RAMP/ON/TRIP permit machine with first-fault capture.
module rpsc_interlock_seq #(
  parameter int N_ALARM    = 8,
  parameter int FILT_CNT   = 3,
  parameter int FILT_W     = 4,
  parameter int TMR_TARGET = 1562500,
  parameter int TMR_W      = 21,
  parameter int LATCH_MODE = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_ALARM-1:0]           alarm_in,
  input  logic [N_ALARM-1:0]           alarm_mask,
  input  logic                         inhibit_in,
  input  logic                         ps_act_in,
  input  logic                         u_low_in,
  input  logic                         clear_in,
  output logic                         not_alarm,
  output logic                         ground_hold_ok,
  output logic                         not_on_perm,
  output logic                         not_ps_on,
  output logic                         ps_ok,
  output logic                         not_ps_ok,
  output logic                         not_u_low,
  output logic [N_ALARM-1:0]           first_fault,
  output logic [$clog2(N_ALARM)-1:0]   fault_code,
  output logic [7:0]                   trip_count,
  output logic [2:0]                   state
);

  localparam int NIN     = N_ALARM + 3;
  localparam int FC_W    = $clog2(N_ALARM);
  localparam int IDX_INH = N_ALARM;
  localparam int IDX_PS  = N_ALARM + 1;
  localparam int IDX_UL  = N_ALARM + 2;
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_CNT - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TMR_TARGET - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_RAMP  = 3'd2,
    S_ON    = 3'd3,
    S_TRIP  = 3'd4
  } state_t;

  function automatic logic [N_ALARM-1:0] lowest_bit(input logic [N_ALARM-1:0] v);
    return v & (~v + N_ALARM'(1));
  endfunction

  function automatic logic [FC_W-1:0] onehot_index(input logic [N_ALARM-1:0] oh);
    logic [FC_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_ALARM; i++)
      if (oh[i]) idx = FC_W'(i);
    return idx;
  endfunction

  logic [NIN-1:0]    raw, sync_p0, sync_p1, filt;
  logic [FILT_W-1:0] fcnt [NIN];
  state_t            st_q, st_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [N_ALARM-1:0] alarm_act;
  logic              alarm_any, inh_f, ps_f, ul_f, trip_release, trip_entry, trip_exit;

  assign raw = {u_low_in, ps_act_in, inhibit_in, alarm_in};

  // Stage p0/p1: two-flop synchroniser on every raw line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: filt flips only after FILT_CNT consecutive disagreeing samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt <= '0;
      for (int i = 0; i < NIN; i++) fcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NIN; i++) begin
        if (sync_p1[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FILT_LAST) begin
          filt[i] <= ~filt[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FILT_W'(1);
        end
      end
    end
  end

  assign alarm_act    = filt[N_ALARM-1:0] & alarm_mask;
  assign alarm_any    = |alarm_act;
  assign inh_f        = filt[IDX_INH];
  assign ps_f         = filt[IDX_PS];
  assign ul_f         = filt[IDX_UL];
  assign trip_release = (LATCH_MODE != 0) ? (clear_in & ~alarm_any) : ~alarm_any;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q  <= S_IDLE;
      tmr_q <= '0;
    end else begin
      st_q  <= st_d;
      tmr_q <= tmr_d;
    end
  end

  // Priority: alarm > inhibit > ps_act drop > ramp timer expiry
  always_comb begin
    st_d = st_q;
    case (st_q)
      S_IDLE: begin
        if (alarm_any)   st_d = S_TRIP;
        else if (!inh_f) st_d = S_READY;
      end
      S_READY, S_RAMP, S_ON: begin
        if (alarm_any)                               st_d = S_TRIP;
        else if (inh_f)                              st_d = S_IDLE;
        else if (st_q == S_READY) begin
          if (ps_f)                                  st_d = S_RAMP;
        end
        else if (!ps_f)                              st_d = S_READY;
        else if (st_q == S_RAMP && tmr_q == TMR_LAST) st_d = S_ON;
      end
      S_TRIP: begin
        if (trip_release) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
    tmr_d = (st_q == S_RAMP && st_d == S_RAMP) ? tmr_q + TMR_W'(1) : '0;
  end

  assign trip_entry = (st_d == S_TRIP) && (st_q != S_TRIP);
  assign trip_exit  = (st_q == S_TRIP) && (st_d != S_TRIP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_fault <= '0;
      fault_code  <= '0;
      trip_count  <= '0;
    end else if (trip_entry) begin
      first_fault <= lowest_bit(alarm_act);
      fault_code  <= onehot_index(lowest_bit(alarm_act));
      if (trip_count != 8'hFF) trip_count <= trip_count + 8'd1;
    end else if (trip_exit && LATCH_MODE != 0) begin
      first_fault <= '0;
      fault_code  <= '0;
    end
  end

  always_comb begin
    ground_hold_ok = (st_q == S_READY) || (st_q == S_RAMP) || (st_q == S_ON);
    not_on_perm    = ~ground_hold_ok;
    ps_ok          = (st_q == S_ON);
    not_ps_ok      = ~ps_ok;
    not_alarm      = ~alarm_any;
    not_ps_on      = ~ps_f;
    not_u_low      = ~(ps_ok & ul_f);
    state          = st_q;
  end

endmodule

// File: tb/tb_rpsc_interlock_seq.sv
// Scoreboard bench: a latched and an auto-recover instance share stimulus and are
// checked every cycle against a behavioural model plus directed scenario checks.
module tb_rpsc_interlock_seq;

  localparam int NA = 4;
  localparam int FCNT = 3;
  localparam int TT = 8;

  typedef struct packed {
    logic [2:0] st;
    logic [6:0] fl;
    logic [3:0] ff;
    logic [1:0] fc;
    logic [7:0] tc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [NA-1:0] alarm_in, alarm_mask;
  logic inhibit_in, ps_act_in, u_low_in, clear_in;

  logic [1:0] na, gh, nop, npo, pok, npok, nul;
  logic [1:0][3:0] ffo;
  logic [1:0][1:0] fco;
  logic [1:0][7:0] tco;
  logic [1:0][2:0] sto;

  always #5 clk = ~clk;

  rpsc_interlock_seq #(.N_ALARM(NA), .FILT_CNT(FCNT), .FILT_W(4), .TMR_TARGET(TT),
                       .TMR_W(4), .LATCH_MODE(1)) u_lat (
    .clk(clk), .reset(reset), .alarm_in(alarm_in), .alarm_mask(alarm_mask),
    .inhibit_in(inhibit_in), .ps_act_in(ps_act_in), .u_low_in(u_low_in), .clear_in(clear_in),
    .not_alarm(na[0]), .ground_hold_ok(gh[0]), .not_on_perm(nop[0]), .not_ps_on(npo[0]),
    .ps_ok(pok[0]), .not_ps_ok(npok[0]), .not_u_low(nul[0]), .first_fault(ffo[0]),
    .fault_code(fco[0]), .trip_count(tco[0]), .state(sto[0]));

  rpsc_interlock_seq #(.N_ALARM(NA), .FILT_CNT(FCNT), .FILT_W(4), .TMR_TARGET(TT),
                       .TMR_W(4), .LATCH_MODE(0)) u_auto (
    .clk(clk), .reset(reset), .alarm_in(alarm_in), .alarm_mask(alarm_mask),
    .inhibit_in(inhibit_in), .ps_act_in(ps_act_in), .u_low_in(u_low_in), .clear_in(clear_in),
    .not_alarm(na[1]), .ground_hold_ok(gh[1]), .not_on_perm(nop[1]), .not_ps_on(npo[1]),
    .ps_ok(pok[1]), .not_ps_ok(npok[1]), .not_u_low(nul[1]), .first_fault(ffo[1]),
    .fault_code(fco[1]), .trip_count(tco[1]), .state(sto[1]));

  int total = 0;
  int bad = 0;
  exp_t q0[$], q1[$];

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic logic [6:0] act_fl(int d);
    return {na[d], gh[d], nop[d], npo[d], pok[d], npok[d], nul[d]};
  endfunction

  // Reference model: delay line + sliding-window debounce, rule-based permit states
  logic [6:0] md1, md2, mf;
  logic [6:0] win[$];
  int mst[2], mage[2], mfc[2], mtc[2];
  logic [3:0] mff[2];

  task automatic model_reset();
    md1 = '0; md2 = '0; mf = '0;
    win.delete();
    for (int d = 0; d < 2; d++) begin
      mst[d] = 0; mage[d] = 0; mfc[d] = 0; mtc[d] = 0; mff[d] = '0;
    end
  endtask

  task automatic model_step();
    logic [3:0] am;
    logic any, inh, ps, all_diff;
    int nx;
    am = mf[3:0] & alarm_mask;
    any = |am; inh = mf[4]; ps = mf[5];
    for (int d = 0; d < 2; d++) begin
      nx = mst[d];
      if (mst[d] == 4) begin
        if (!any && (d == 1 || clear_in)) nx = 0;
      end
      else if (any)                               nx = 4;
      else if (mst[d] == 0)                       nx = inh ? 0 : 1;
      else if (inh)                               nx = 0;
      else if (mst[d] == 1)                       nx = ps ? 2 : 1;
      else if (!ps)                               nx = 1;
      else if (mst[d] == 2 && mage[d] == TT - 1)  nx = 3;
      mage[d] = (mst[d] == 2 && nx == 2) ? mage[d] + 1 : 0;
      if (nx == 4 && mst[d] != 4) begin
        for (int i = NA - 1; i >= 0; i--) if (am[i]) mfc[d] = i;
        mff[d] = 4'(1 << mfc[d]);
        if (mtc[d] < 255) mtc[d]++;
      end else if (mst[d] == 4 && nx != 4 && d == 0) begin
        mff[d] = '0; mfc[d] = 0;
      end
      mst[d] = nx;
    end
    win.push_back(md2);
    if (win.size() > FCNT) void'(win.pop_front());
    if (win.size() == FCNT) begin
      for (int b = 0; b < 7; b++) begin
        all_diff = 1'b1;
        foreach (win[i]) if (win[i][b] == mf[b]) all_diff = 1'b0;
        if (all_diff) mf[b] = ~mf[b];
      end
    end
    md2 = md1;
    md1 = {u_low_in, ps_act_in, inhibit_in, alarm_in};
  endtask

  function automatic exp_t mexp(int d);
    exp_t e;
    logic any, g, on;
    any = |(mf[3:0] & alarm_mask);
    g = (mst[d] >= 1) && (mst[d] <= 3);
    on = (mst[d] == 3);
    e.st = 3'(mst[d]);
    e.fl = {~any, g, ~g, ~mf[5], on, ~on, ~(on & mf[6])};
    e.ff = mff[d];
    e.fc = 2'(mfc[d]);
    e.tc = 8'(mtc[d]);
    return e;
  endfunction

  task automatic cmp(int d, exp_t e);
    chk($sformatf("state%0d", d), 32'(sto[d]), 32'(e.st));
    chk($sformatf("flags%0d", d), 32'(act_fl(d)), 32'(e.fl));
    chk($sformatf("first_fault%0d", d), 32'(ffo[d]), 32'(e.ff));
    chk($sformatf("fault_code%0d", d), 32'(fco[d]), 32'(e.fc));
    chk($sformatf("trip_count%0d", d), 32'(tco[d]), 32'(e.tc));
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) cmp(0, q0.pop_front());
    if (q1.size() > 0) cmp(1, q1.pop_front());
  end

  task automatic step();
    exp_t e0, e1;
    model_step();
    e0 = mexp(0);
    e1 = mexp(1);
    @(posedge clk);
    q0.push_back(e0);
    q1.push_back(e1);
    @(negedge clk);
    #1;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic wait_st(int d, int s, int budget, output int n);
    n = 0;
    while (32'(sto[d]) != s && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic chk_reset();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_state%0d", d), 32'(sto[d]), 0);
      chk($sformatf("rst_flags%0d", d), 32'(act_fl(d)), 32'h5B);
      chk($sformatf("rst_ff%0d", d), 32'(ffo[d]), 0);
      chk($sformatf("rst_fc%0d", d), 32'(fco[d]), 0);
      chk($sformatf("rst_tc%0d", d), 32'(tco[d]), 0);
    end
  endtask

  task automatic pulse_clear();
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    alarm_in = '0; alarm_mask = 4'hF;
    inhibit_in = 1'b0; ps_act_in = 1'b0; u_low_in = 1'b0; clear_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_reset();
    @(negedge clk);
    #1 reset = 1'b1;

    // Power-up
    step();
    chk("ready_first", 32'(sto[0]), 1);
    ps_act_in = 1'b1;
    wait_st(0, 2, 20, n); chk("ramp_lat", 32'(n), 6);
    wait_st(0, 3, 20, n); chk("on_lat", 32'(n), 8);
    chk("not_ps_ok_on", 32'(npok[0]), 0);

    // Glitch rejection
    alarm_in[2] = 1'b1;
    run(2);
    alarm_in = '0;
    run(10);
    chk("glitch_state", 32'(sto[0]), 3);
    chk("glitch_tc", 32'(tco[0]), 0);

    // Trip capture and latch
    alarm_in = 4'b1100;
    wait_st(0, 4, 20, n); chk("trip_lat", 32'(n), 6);
    chk("trip_ff", 32'(ffo[0]), 32'h4);
    chk("trip_fc", 32'(fco[0]), 2);
    chk("trip_tc", 32'(tco[0]), 1);
    pulse_clear();
    run(3);
    chk("clear_ignored", 32'(sto[0]), 4);
    alarm_in = '0;
    wait_st(1, 0, 20, n); chk("auto_idle_lat", 32'(n), 6);
    chk("auto_ff_kept", 32'(ffo[1]), 32'h4);
    chk("latched_holds", 32'(sto[0]), 4);
    pulse_clear();
    chk("clear_idle", 32'(sto[0]), 0);
    chk("clear_ff", 32'(ffo[0]), 0);

    // Masking
    wait_st(0, 3, 40, n);
    alarm_mask = 4'b1110;
    alarm_in[0] = 1'b1;
    run(10);
    chk("mask_not_alarm", 32'(na[0]), 1);
    chk("mask_no_trip", 32'(sto[0]), 3);
    alarm_mask = 4'hF;
    step();
    chk("unmask_trip", 32'(sto[0]), 4);
    chk("unmask_ff", 32'(ffo[0]), 32'h1);
    alarm_in = '0;
    run(8);
    pulse_clear();

    // Ramp abort at timer=5, then a full-length ramp
    wait_st(0, 2, 20, n);
    ps_act_in = 1'b0;
    wait_st(0, 1, 20, n); chk("abort_lat", 32'(n), 6);
    ps_act_in = 1'b1;
    wait_st(0, 2, 20, n);
    wait_st(0, 3, 20, n); chk("reramp_len", 32'(n), 8);

    // Alarm beats inhibit
    inhibit_in = 1'b1;
    alarm_in = 4'b0010;
    wait_st(0, 4, 20, n); chk("prio_lat", 32'(n), 6);
    chk("prio_fc", 32'(fco[0]), 1);
    alarm_in = '0; inhibit_in = 1'b0;
    run(8);
    pulse_clear();
    run(2);

    // Reset while tripped
    alarm_in = 4'b0001;
    run(8);
    chk("pre_reset_trip", 32'(sto[0]), 4);
    alarm_in = '0;
    reset = 1'b0;
    #1 chk_reset();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;

    // Randomised traffic
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(19) == 0) begin
        int k;
        k = int'($urandom_range(3));
        alarm_in[k] = ~alarm_in[k];
      end
      if ($urandom_range(29) == 0) inhibit_in = ~inhibit_in;
      if ($urandom_range(24) == 0) ps_act_in = ~ps_act_in;
      if ($urandom_range(9) == 0) u_low_in = ~u_low_in;
      if ($urandom_range(49) == 0) alarm_mask = 4'($urandom);
      clear_in = ($urandom_range(7) == 0);
      step();
    end

    // Trip counter saturation
    alarm_in = '0; alarm_mask = 4'hF; inhibit_in = 1'b0; ps_act_in = 1'b0; clear_in = 1'b0;
    run(8);
    pulse_clear();
    step();
    for (int t = 0; t < 260; t++) begin
      alarm_in = 4'b1000;
      run(8);
      alarm_in = '0;
      run(8);
      pulse_clear();
      step();
    end
    chk("sat_tc0", 32'(tco[0]), 255);
    chk("sat_tc1", 32'(tco[1]), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
